dmem_lsu: RTL and testbench
===========================

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of both the CPU-side and memory-side addresses.
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU access request
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, extended
- resp_err  out  1  misaligned access, valid with resp_valid
- dmem_read  out  1  word read strobe
- dmem_write  out  1  word write strobe
- dmem_addr  out  ADDR_W  word-aligned address, bits [1:0]=00
- dmem_wdata  out  32  write data
- dmem_rdata  in  32  read data, valid the cycle after dmem_read (synchronous RAM, no byte enables)

Function
REQ-003 SHALL implement FSM states IDLE, RD, CAP, WR, RESP; req_ready=1 only in IDLE; a request is accepted when req_valid&req_ready, and all req_* fields are registered on acceptance.
REQ-004 Load, accepted cycle T: RD at T+1 (dmem_read=1); CAP at T+2 (dmem_rdata lane-extracted and registered); RESP at T+3 (resp_valid=1); IDLE at T+4.
REQ-005 Word store, accepted at T: WR at T+1 (dmem_write=1, dmem_wdata=req_wdata); RESP at T+2.
REQ-006 Byte/half store SHALL use read-modify-write: RD at T+1; WR at T+2 with dmem_wdata = dmem_rdata with only the addressed lane(s) replaced; RESP at T+3.
REQ-007 Lanes SHALL be little-endian: byte lane = addr[1:0]; half lane = addr[1].
REQ-008 B/H loads SHALL sign-extend; BU/HU loads SHALL zero-extend; W returns the word unchanged.
REQ-009 funct3 values 011, 110 and 111 SHALL be treated as W.
REQ-010 dmem_read and dmem_write SHALL never be asserted in the same cycle, and each SHALL be asserted for exactly one cycle per access.
REQ-011 resp_rdata SHALL hold its last value outside RESP; resp_rdata SHALL be 0 for stores.
REQ-012 Requests presented while req_ready=0 SHALL be ignored and not queued.

Reset
REQ-013 While rst=1 at a clock edge: state goes to IDLE; req_ready=1; resp_valid, resp_err, dmem_read and dmem_write go to 0; resp_rdata, dmem_addr and dmem_wdata go to 0.
REQ-014 Reset mid-operation SHALL abort the access: no dmem_write in the cycle after reset, including when reset arrives in RD of an RMW; no resp_valid is produced.

Configuration
REQ-015 With LSU_MISALIGN_TRAP_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL go IDLE->RESP at T+1 with resp_err=1, no dmem strobe, and resp_rdata unchanged.
REQ-016 Without LSU_MISALIGN_TRAP_EN: misaligned low address bits SHALL be cleared to the access size's natural alignment before use, and resp_err SHALL be tied to 0.

Verification
REQ-017 Memory word 0x10=0x8899AABB, LB at 0x13 -> resp_rdata=0xFFFFFF88 at T+3; LBU at 0x13 -> 0x00000088.
REQ-018 Memory word 0x20=0x11223344, SH 0x0000BEEF at 0x22 -> one read, then a write of 0xBEEF3344 at T+2; resp_valid at T+3.
REQ-019 SW 0xDEADBEEF at 0x40 -> dmem_write at T+1 only, dmem_addr=0x40, no dmem_read; then LW at 0x40 -> 0xDEADBEEF.
REQ-020 Misaligned LW at 0x41 -> with the macro: resp_err=1 at T+1 and no strobes; without the macro: reads word 0x40, resp_err=0.
REQ-021 rst pulsed during RD of an SB -> no dmem_write follows; req_ready=1 the cycle after reset.
REQ-022 Back-to-back LW/SW with req_valid held high -> each accepted only in IDLE, responses in order, no strobe overlap.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte/half/word load-store unit with RMW sub-word stores; define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
module dmem_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;
  state_t state, nxt;
  logic accept, trap, we_q, uns_q;
  logic [1:0] sz, lo, sz_q, lo_q;
  logic [31:0] wdata_q, bmask, hmask, bmerge, hmerge, ext;
  logic [7:0] bsel;
  logic [15:0] hsel;
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign dmem_read = state == RD;
  assign dmem_write = state == WR;
  assign accept = req_valid & req_ready;
  assign sz = req_funct3[1:0] == 2'b00 ? 2'd0 : req_funct3[1:0] == 2'b01 ? 2'd1 : 2'd2;
  assign lo = sz == 2'd0 ? req_addr[1:0] : sz == 2'd1 ? {req_addr[1], 1'b0} : 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  assign trap = (sz == 2'd1 & req_addr[0]) | (sz == 2'd2 & |req_addr[1:0]);
  assign resp_err = resp_valid & err_q;
`else
  assign trap = 1'b0;
  assign resp_err = 1'b0;
`endif
  assign bsel = dmem_rdata[{lo_q, 3'b000} +: 8];
  assign hsel = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign ext = sz_q == 2'd0 ? {{24{~uns_q & bsel[7]}}, bsel} :
               sz_q == 2'd1 ? {{16{~uns_q & hsel[15]}}, hsel} : dmem_rdata;
  assign bmask = 32'h0000_00ff << {lo_q, 3'b000};
  assign hmask = lo_q[1] ? 32'hffff_0000 : 32'h0000_ffff;
  assign bmerge = (dmem_rdata & ~bmask) | ({4{wdata_q[7:0]}} & bmask);
  assign hmerge = (dmem_rdata & ~hmask) | ({2{wdata_q[15:0]}} & hmask);
  assign dmem_wdata = dmem_write ? (sz_q == 2'd0 ? bmerge : sz_q == 2'd1 ? hmerge : wdata_q) : 32'd0;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = !accept ? IDLE : trap ? RESP : (req_we & sz == 2'd2) ? WR : RD;
      RD:      nxt = we_q ? WR : CAP;
      CAP:     nxt = RESP;
      WR:      nxt = RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      resp_rdata <= '0;
      dmem_addr <= '0;
    end else begin
      state <= nxt;
      if (accept) dmem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
      if (state == CAP) resp_rdata <= ext;
      if (state == WR) resp_rdata <= '0;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q <= req_we;
      uns_q <= req_funct3[2];
      sz_q <= sz;
      lo_q <= lo;
      wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q <= trap;
`endif
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: table-driven directed bench for dmem_lsu with a synchronous word RAM model
module tb_dmem_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_we = 1'b0;
  logic [2:0] req_funct3 = 3'b010;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic resp_valid, resp_err, dmem_read, dmem_write;
  logic [31:0] resp_rdata, dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic pre_we = 1'b0;
  logic [5:0] pre_idx = '0;
  logic [31:0] pre_dat = '0;
  logic [31:0] mem [64];
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rd;
    int          wr;
    int          rv;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        err;
  } vec_t;
  vec_t vt[$];
  vec_t bb[$];
  logic [31:0] bb_exp[$];
  dmem_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_dat;
    if (dmem_write) mem[dmem_addr[7:2]] <= dmem_wdata;
    if (dmem_read) dmem_rdata <= mem[dmem_addr[7:2]];
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, got, exp);
    end
  endtask
  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                     input int rd, input int wr, input int rv, input logic [31:0] rdata,
                     input logic [31:0] maddr, input logic [31:0] mwdata, input logic err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.wr = wr; v.rv = rv;
    v.rdata = rdata; v.maddr = maddr; v.mwdata = mwdata; v.err = err;
    vt.push_back(v);
  endtask
  task automatic preload(input logic [5:0] idx, input logic [31:0] dat);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_dat = dat;
    @(negedge clk);
    pre_we = 1'b0;
  endtask
  task automatic run_vec(input int n, input vec_t v);
    int nrd, nwr, nrv, rdc, wrc, rvc, ovl;
    logic [31:0] ad, wd, rdat, hold;
    logic e;
    nrd = 0; nwr = 0; nrv = 0; rdc = 0; wrc = 0; rvc = 0; ovl = 0;
    ad = '0; wd = '0; rdat = '0; hold = '0; e = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    chk($sformatf("v%0d ready_idle", n), {31'd0, req_ready}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        chk($sformatf("v%0d ready_busy", n), {31'd0, req_ready}, 32'd0);
      end
      if (dmem_read) begin nrd++; rdc = k; ad = dmem_addr; end
      if (dmem_write) begin nwr++; wrc = k; wd = dmem_wdata; ad = dmem_addr; end
      if (dmem_read && dmem_write) ovl++;
      if (resp_valid) begin nrv++; rvc = k; rdat = resp_rdata; e = resp_err; end
      if (k == 5) hold = resp_rdata;
    end
    chk($sformatf("v%0d rd_count", n), nrd, (v.rd != 0) ? 1 : 0);
    chk($sformatf("v%0d wr_count", n), nwr, (v.wr != 0) ? 1 : 0);
    chk($sformatf("v%0d rd_cycle", n), rdc, v.rd);
    chk($sformatf("v%0d wr_cycle", n), wrc, v.wr);
    chk($sformatf("v%0d resp_count", n), nrv, 1);
    chk($sformatf("v%0d resp_cycle", n), rvc, v.rv);
    chk($sformatf("v%0d overlap", n), ovl, 0);
    chk($sformatf("v%0d resp_rdata", n), rdat, v.rdata);
    chk($sformatf("v%0d resp_err", n), {31'd0, e}, {31'd0, v.err});
    chk($sformatf("v%0d rdata_hold", n), hold, v.rdata);
    if (v.rd != 0 || v.wr != 0) chk($sformatf("v%0d dmem_addr", n), ad, v.maddr);
    if (v.wr != 0) chk($sformatf("v%0d dmem_wdata", n), wd, v.mwdata);
  endtask
  initial begin
    int i, nresp, nr, nw, ovl, nwr_rst, nrv_rst;
    logic acc;
    vec_t b;
    add(0, 3'b000, 32'h13, 0, 1, 0, 3, 32'hFFFFFF88, 32'h10, 0, 0);
    add(0, 3'b100, 32'h13, 0, 1, 0, 3, 32'h00000088, 32'h10, 0, 0);
    add(0, 3'b001, 32'h12, 0, 1, 0, 3, 32'hFFFF8899, 32'h10, 0, 0);
    add(0, 3'b101, 32'h10, 0, 1, 0, 3, 32'h0000AABB, 32'h10, 0, 0);
    add(0, 3'b001, 32'h10, 0, 1, 0, 3, 32'hFFFFAABB, 32'h10, 0, 0);
    add(0, 3'b000, 32'h10, 0, 1, 0, 3, 32'hFFFFFFBB, 32'h10, 0, 0);
    add(0, 3'b100, 32'h11, 0, 1, 0, 3, 32'h000000AA, 32'h10, 0, 0);
    add(0, 3'b010, 32'h10, 0, 1, 0, 3, 32'h8899AABB, 32'h10, 0, 0);
    add(1, 3'b001, 32'h22, 32'h0000BEEF, 1, 2, 3, 0, 32'h20, 32'hBEEF3344, 0);
    add(0, 3'b010, 32'h20, 0, 1, 0, 3, 32'hBEEF3344, 32'h20, 0, 0);
    add(1, 3'b000, 32'h21, 32'h000000A5, 1, 2, 3, 0, 32'h20, 32'hBEEFA544, 0);
    add(0, 3'b010, 32'h20, 0, 1, 0, 3, 32'hBEEFA544, 32'h20, 0, 0);
    add(1, 3'b010, 32'h40, 32'hDEADBEEF, 0, 1, 2, 0, 32'h40, 32'hDEADBEEF, 0);
    add(0, 3'b010, 32'h40, 0, 1, 0, 3, 32'hDEADBEEF, 32'h40, 0, 0);
    add(0, 3'b011, 32'h40, 0, 1, 0, 3, 32'hDEADBEEF, 32'h40, 0, 0);
    add(0, 3'b110, 32'h40, 0, 1, 0, 3, 32'hDEADBEEF, 32'h40, 0, 0);
    add(0, 3'b111, 32'h40, 0, 1, 0, 3, 32'hDEADBEEF, 32'h40, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    add(0, 3'b010, 32'h41, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 1);
    add(0, 3'b001, 32'h11, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 1);
`else
    add(0, 3'b010, 32'h41, 0, 1, 0, 3, 32'hDEADBEEF, 32'h40, 0, 0);
    add(0, 3'b001, 32'h11, 0, 1, 0, 3, 32'hFFFFAABB, 32'h10, 0, 0);
`endif
    add(1, 3'b000, 32'h40, 32'hFFFFFF77, 1, 2, 3, 0, 32'h40, 32'hDEADBE77, 0);
    add(0, 3'b100, 32'h40, 0, 1, 0, 3, 32'h00000077, 32'h40, 0, 0);
    add(0, 3'b000, 32'h43, 0, 1, 0, 3, 32'hFFFFFFDE, 32'h40, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    add(1, 3'b001, 32'h43, 32'h00001234, 0, 0, 1, 32'hFFFFFFDE, 0, 0, 1);
    add(0, 3'b010, 32'h40, 0, 1, 0, 3, 32'hDEADBE77, 32'h40, 0, 0);
    add(1, 3'b000, 32'h43, 32'h00000099, 1, 2, 3, 0, 32'h40, 32'h99ADBE77, 0);
    add(0, 3'b010, 32'h40, 0, 1, 0, 3, 32'h99ADBE77, 32'h40, 0, 0);
`else
    add(1, 3'b001, 32'h43, 32'h00001234, 1, 2, 3, 0, 32'h40, 32'h1234BE77, 0);
    add(0, 3'b010, 32'h40, 0, 1, 0, 3, 32'h1234BE77, 32'h40, 0, 0);
    add(1, 3'b000, 32'h43, 32'h00000099, 1, 2, 3, 0, 32'h40, 32'h9934BE77, 0);
    add(0, 3'b010, 32'h40, 0, 1, 0, 3, 32'h9934BE77, 32'h40, 0, 0);
`endif
    preload(6'h04, 32'h8899AABB);
    preload(6'h08, 32'h11223344);
    preload(6'h14, 32'h55667788);
    @(negedge clk);
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst dmem_read", {31'd0, dmem_read}, 32'd0);
    chk("rst dmem_write", {31'd0, dmem_write}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst dmem_addr", dmem_addr, 32'd0);
    chk("rst dmem_wdata", dmem_wdata, 32'd0);
    rst = 1'b0;
    foreach (vt[n]) run_vec(n, vt[n]);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h51; req_wdata = 32'h000000AB;
    @(negedge clk);
    chk("mid_rst rd_strobe", {31'd0, dmem_read}, 32'd1);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst dmem_write", {31'd0, dmem_write}, 32'd0);
    chk("mid_rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst resp_rdata", resp_rdata, 32'd0);
    chk("mid_rst dmem_addr", dmem_addr, 32'd0);
    rst = 1'b0;
    nwr_rst = 0; nrv_rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nwr_rst += int'(dmem_write);
      nrv_rst += int'(resp_valid);
    end
    chk("mid_rst later_writes", nwr_rst, 0);
    chk("mid_rst later_resps", nrv_rst, 0);
    b.we = 0; b.f3 = 3'b010; b.addr = 32'h50; b.wdata = 0; b.rd = 1; b.wr = 0; b.rv = 3;
    b.rdata = 32'h55667788; b.maddr = 32'h50; b.mwdata = 0; b.err = 0;
    run_vec(100, b);
    b.we = 0; b.f3 = 3'b010; b.addr = 32'h10; b.wdata = 0; bb.push_back(b); bb_exp.push_back(32'h8899AABB);
    b.we = 1; b.f3 = 3'b010; b.addr = 32'h60; b.wdata = 32'h12345678; bb.push_back(b); bb_exp.push_back(32'h0);
    b.we = 0; b.f3 = 3'b010; b.addr = 32'h60; b.wdata = 0; bb.push_back(b); bb_exp.push_back(32'h12345678);
    b.we = 0; b.f3 = 3'b100; b.addr = 32'h61; b.wdata = 0; bb.push_back(b); bb_exp.push_back(32'h00000056);
    i = 0; acc = 1'b0; nresp = 0; nr = 0; nw = 0; ovl = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dmem_read && dmem_write) ovl++;
      nr += int'(dmem_read);
      nw += int'(dmem_write);
      if (resp_valid) begin
        if (nresp < 4) chk($sformatf("b2b resp%0d", nresp), resp_rdata, bb_exp[nresp]);
        nresp++;
      end
      if (acc) i++;
      if (i < 4) begin
        req_valid = 1'b1; req_we = bb[i].we; req_funct3 = bb[i].f3; req_addr = bb[i].addr; req_wdata = bb[i].wdata;
      end else req_valid = 1'b0;
      acc = req_valid && req_ready;
    end
    chk("b2b resp_count", nresp, 4);
    chk("b2b read_count", nr, 3);
    chk("b2b write_count", nw, 1);
    chk("b2b overlap", ovl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
